fir3_stream_ctrl: RTL and testbench
===================================

// Module: fir3_stream_ctrl
// PURPOSE
// - Stream scheduler around the 3-way unfolded FIR (DIN0/1/2 -> DOUT0/1/2).
// - Packs a serial sample stream into 3-lane groups and issues one VIN pulse per group.
// - Buffers returned 3-lane result groups and serializes them back into one sample per cycle.
// - Sits between the serial sample source/sink and the FIR core. Clock and reset are shared.
// PARAMETERS
// - NB  13  sample width of all data lanes, serial and parallel
// PORTS
// - CLK      in   1   clock; all logic on rising edge
// - RST      in   1   asynchronous, active-high reset
// - S_DIN    in   NB  serial input sample
// - S_VIN    in   1   S_DIN valid
// - F_DIN0   out  NB  to FIR DIN0; oldest sample of group, x[3k]
// - F_DIN1   out  NB  to FIR DIN1; x[3k+1]
// - F_DIN2   out  NB  to FIR DIN2; x[3k+2]
// - F_VIN    out  1   to FIR VIN; 1-cycle pulse per group
// - F_DOUT0  in   NB  from FIR DOUT0 (y[3k]); DOUT1/DOUT2 map to F_DOUT1/F_DOUT2 likewise
// - F_DOUT1  in   NB  from FIR DOUT1
// - F_DOUT2  in   NB  from FIR DOUT2
// - F_VOUT   in   1   from FIR VOUT; result group valid
// - S_DOUT   out  NB  serial output sample
// - S_VOUT   out  1   S_DOUT valid
// - OVF      out  1   sticky: a result group was dropped
// - FLUSH    in   1   pad and issue a partial group; port exists only with FIR3_CTRL_FLUSH_EN
// BEHAVIOUR
// - Reset: F_DIN0..2=0, F_VIN=0, S_DOUT=0, S_VOUT=0, OVF=0, lane count=0, result buffer empty.
// - Reset mid-group or mid-burst discards the partial group and all buffered results.
// Packer
// - Lane counter cnt cycles 0->1->2->0 on each cycle with S_VIN=1; cnt holds when S_VIN=0.
// - S_VIN at cnt=0 stores lane0. S_VIN at cnt=1 stores lane1.
// - S_VIN at cnt=2 registers F_DIN0=lane0, F_DIN1=lane1, F_DIN2=S_DIN and sets F_VIN=1.
// - Latency: F_VIN is high on the cycle after the 3rd accepted sample. It is high for exactly 1 cycle.
// - F_DIN0..2 hold their values until the next group is issued.
// - Input gaps of any length are allowed. The packer accepts up to 1 sample/cycle, so F_VIN pulses are >=3 cycles apart.
// Result buffer and serializer
// - The result buffer is a 2-entry FIFO of 3-lane groups. F_VOUT=1 pushes {F_DOUT0,F_DOUT1,F_DOUT2}.
// - Serializer states: IDLE, L0, L1, L2.
// - IDLE -> L0 when the FIFO is non-empty.
// - In L0, L1 and L2: S_VOUT=1 and S_DOUT = head lane 0, 1, 2 respectively (registered outputs).
// - L2 pops the head. L2 -> L0 if another entry remains after the pop (no bubble). Otherwise L2 -> IDLE.
// - Latency: F_VOUT at cycle t into an empty FIFO gives lane0 on S_DOUT at t+1, lane1 at t+2, lane2 at t+3.
// - In IDLE: S_VOUT=0 and S_DOUT holds its last value.
// - Push and pop in the same cycle with the FIFO full: the pop frees a slot and the push is accepted (no overflow).
// - Push with the FIFO full and no pop that cycle: the incoming group is dropped and OVF is set to 1. OVF clears only on RST.
// CONFIGURATION
// - Macro FIR3_CTRL_FLUSH_EN defined: the FLUSH port exists.
//   - FLUSH=1 with cnt!=0 issues the partial group next cycle. Missing lanes are 0. cnt goes to 0.
//   - FLUSH=1 with cnt=0 does nothing.
//   - FLUSH and S_VIN in the same cycle: the sample is taken first.
//     - If that sample completes the group, a normal group is issued and the flush has no effect.
//     - Otherwise the padded group includes the new sample.
// - Macro FIR3_CTRL_FLUSH_EN undefined: no FLUSH port and no flush logic. A partial group waits indefinitely.
// TESTING
// - T1 reset: assert RST mid-run -> all outputs 0 in the same cycle; after release, first group = next 3 fresh samples.
// - T2 back-to-back: S_DIN=1..6, one per cycle -> F_VIN pulses 1 cycle after sample 3 and after sample 6.
//   - F_DIN={1,2,3} then {4,5,6}.
//   - Loopback (F_DOUT=F_DIN, F_VOUT=F_VIN delayed 2 cycles) -> S_DOUT=1,2,3,4,5,6 on 6 contiguous S_VOUT cycles.
// - T3 gapped input: 7, idle 1 cycle, 8, idle 2 cycles, 9 -> single F_VIN pulse with F_DIN={7,8,9}. cnt returns to 0.
// - T4 flush (FIR3_CTRL_FLUSH_EN): samples 10,11 then FLUSH -> F_DIN={10,11,0}.
//   - FLUSH at cnt=0 -> no F_VIN.
// - T5 overflow: F_VOUT high 3 consecutive cycles with groups A,B,C into an empty FIFO -> C dropped and OVF=1.
//   - S_DOUT then shows A0,A1,A2,B0,B1,B2 with no gap.
// - T6 full push+pop: FIFO full, push on the cycle the serializer is in L2 -> push accepted, OVF stays 0.

Source files
------------

// File: rtl/fir3_stream_ctrl.sv
// Serial <-> 3-lane stream scheduler around the unfolded FIR3 core.
// Optional partial-group flush: define FIR3_CTRL_FLUSH_EN to add the FLUSH port.
module fir3_stream_ctrl #(
  parameter int NB = 13
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [NB-1:0] S_DIN,
  input  logic          S_VIN,
  output logic [NB-1:0] F_DIN0,
  output logic [NB-1:0] F_DIN1,
  output logic [NB-1:0] F_DIN2,
  output logic          F_VIN,
  input  logic [NB-1:0] F_DOUT0,
  input  logic [NB-1:0] F_DOUT1,
  input  logic [NB-1:0] F_DOUT2,
  input  logic          F_VOUT,
  output logic [NB-1:0] S_DOUT,
  output logic          S_VOUT,
  output logic          OVF
`ifdef FIR3_CTRL_FLUSH_EN
  ,
  input  logic          FLUSH
`endif
);

  typedef logic [2:0][NB-1:0] grp_t;
  typedef enum logic [1:0] {IDLE, L0, L1, L2} ser_t;

  logic [1:0]    cnt;
  logic [NB-1:0] lane0;
  logic [NB-1:0] lane1;

`ifdef FIR3_CTRL_FLUSH_EN
  // A sample that completes the group wins over the flush.
  logic flush_go;
  assign flush_go = FLUSH
                 && !(S_VIN && cnt == 2'd2)
                 && (S_VIN || cnt != 2'd0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt    <= 2'd0;
      lane0  <= '0;
      lane1  <= '0;
      F_DIN0 <= '0;
      F_DIN1 <= '0;
      F_DIN2 <= '0;
      F_VIN  <= 1'b0;
    end else begin
      F_VIN <= 1'b0;
      if (S_VIN) begin
        unique case (cnt)
          2'd0: begin
            lane0 <= S_DIN;
            cnt   <= 2'd1;
          end
          2'd1: begin
            lane1 <= S_DIN;
            cnt   <= 2'd2;
          end
          2'd2: begin
            F_DIN0 <= lane0;
            F_DIN1 <= lane1;
            F_DIN2 <= S_DIN;
            F_VIN  <= 1'b1;
            cnt    <= 2'd0;
          end
          default: cnt <= 2'd0;
        endcase
      end
`ifdef FIR3_CTRL_FLUSH_EN
      if (flush_go) begin
        F_VIN <= 1'b1;
        cnt   <= 2'd0;
        unique case (cnt)
          2'd0: begin
            F_DIN0 <= S_DIN;
            F_DIN1 <= '0;
            F_DIN2 <= '0;
          end
          2'd1: begin
            F_DIN0 <= lane0;
            F_DIN1 <= S_VIN ? S_DIN : '0;
            F_DIN2 <= '0;
          end
          default: begin
            F_DIN0 <= lane0;
            F_DIN1 <= lane1;
            F_DIN2 <= '0;
          end
        endcase
      end
`endif
    end
  end

  ser_t          state;
  ser_t          state_nxt;
  grp_t          mem [2];
  logic          rd;
  logic          wr;
  logic [1:0]    fill;
  logic          pop;
  logic          push;
  logic          drop;
  grp_t          in_grp;
  grp_t          head;
  grp_t          after_pop;
  logic [NB-1:0] dout_nxt;
  logic          vout_nxt;

  assign in_grp    = {F_DOUT2, F_DOUT1, F_DOUT0};
  assign head      = mem[rd];
  assign pop       = (state == L2);
  assign push      = F_VOUT && (fill != 2'd2 || pop);
  assign drop      = F_VOUT && fill == 2'd2 && !pop;
  // An incoming group bypasses the buffer when it becomes the head at once.
  assign after_pop = (fill == 2'd2) ? mem[~rd] : in_grp;

  always_comb begin
    state_nxt = state;
    dout_nxt  = S_DOUT;
    vout_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill != 2'd0) begin
          state_nxt = L0;
          dout_nxt  = head[0];
          vout_nxt  = 1'b1;
        end else if (F_VOUT) begin
          state_nxt = L0;
          dout_nxt  = in_grp[0];
          vout_nxt  = 1'b1;
        end
      end
      L0: begin
        state_nxt = L1;
        dout_nxt  = head[1];
        vout_nxt  = 1'b1;
      end
      L1: begin
        state_nxt = L2;
        dout_nxt  = head[2];
        vout_nxt  = 1'b1;
      end
      L2: begin
        if (fill == 2'd2 || push) begin
          state_nxt = L0;
          dout_nxt  = after_pop[0];
          vout_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      S_DOUT <= '0;
      S_VOUT <= 1'b0;
      OVF    <= 1'b0;
      fill   <= 2'd0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state  <= state_nxt;
      S_DOUT <= dout_nxt;
      S_VOUT <= vout_nxt;
      if (drop) OVF <= 1'b1;
      fill <= fill + {1'b0, push} - {1'b0, pop};
      if (push) begin
        mem[wr] <= in_grp;
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
    end
  end

endmodule

// File: tb/tb_fir3_stream_ctrl.sv
// Randomized bench for fir3_stream_ctrl against a queue-based reference model.
// Flush scenarios run only when FIR3_CTRL_FLUSH_EN is defined.
module tb_fir3_stream_ctrl;

  localparam int NB = 13;
  typedef logic [2:0][NB-1:0] grp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NB-1:0] S_DIN;
  logic          S_VIN;
  logic [NB-1:0] F_DIN0, F_DIN1, F_DIN2;
  logic          F_VIN;
  logic [NB-1:0] F_DOUT0, F_DOUT1, F_DOUT2;
  logic          F_VOUT;
  logic [NB-1:0] S_DOUT;
  logic          S_VOUT;
  logic          OVF;
`ifdef FIR3_CTRL_FLUSH_EN
  logic          FLUSH;
`endif

  always #5 CLK = ~CLK;

  fir3_stream_ctrl #(.NB(NB)) dut (
    .CLK(CLK), .RST(RST),
    .S_DIN(S_DIN), .S_VIN(S_VIN),
    .F_DIN0(F_DIN0), .F_DIN1(F_DIN1), .F_DIN2(F_DIN2),
    .F_VIN(F_VIN),
    .F_DOUT0(F_DOUT0), .F_DOUT1(F_DOUT1), .F_DOUT2(F_DOUT2),
    .F_VOUT(F_VOUT),
    .S_DOUT(S_DOUT), .S_VOUT(S_VOUT), .OVF(OVF)
`ifdef FIR3_CTRL_FLUSH_EN
    , .FLUSH(FLUSH)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] pend [$];
  grp_t          fifo_q [$];
  int            pos;
  grp_t          exp_fd;
  logic          exp_fvin;
  logic          exp_svout;
  logic [NB-1:0] exp_sdout;
  logic          exp_ovf;
  logic          d1v, d2v;
  grp_t          d1g, d2g;
  bit            lb;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic grp_t mk(input logic [NB-1:0] a, b, c);
    grp_t g;
    g[0] = a;
    g[1] = b;
    g[2] = c;
    return g;
  endfunction

  task automatic model_reset();
    pend.delete();
    fifo_q.delete();
    pos       = 0;
    exp_fd    = '0;
    exp_fvin  = 1'b0;
    exp_svout = 1'b0;
    exp_sdout = '0;
    exp_ovf   = 1'b0;
    d1v = 1'b0; d2v = 1'b0;
    d1g = '0;   d2g = '0;
  endtask

  // Predicts the outputs after the next rising edge.
  task automatic model_step(input logic vin, input logic [NB-1:0] din,
                            input logic fl, input logic fv, input grp_t g);
    exp_fvin = 1'b0;
    if (vin) begin
      pend.push_back(din);
      if (pend.size() == 3) begin
        exp_fd   = mk(pend[0], pend[1], pend[2]);
        exp_fvin = 1'b1;
        pend.delete();
      end
    end
`ifdef FIR3_CTRL_FLUSH_EN
    if (fl && pend.size() != 0) begin
      exp_fd = '0;
      foreach (pend[i]) exp_fd[i] = pend[i];
      exp_fvin = 1'b1;
      pend.delete();
    end
`endif
    if (pos == 3) begin
      void'(fifo_q.pop_front());
      pos = 0;
    end
    if (fv) begin
      if (fifo_q.size() < 2) fifo_q.push_back(g);
      else exp_ovf = 1'b1;
    end
    exp_svout = 1'b0;
    if (fifo_q.size() != 0 && pos < 3) begin
      exp_sdout = fifo_q[0][pos];
      pos++;
      exp_svout = 1'b1;
    end
  endtask

  task automatic check_all();
    check("f_vin",  F_VIN,  exp_fvin);
    check("f_din0", F_DIN0, exp_fd[0]);
    check("f_din1", F_DIN1, exp_fd[1]);
    check("f_din2", F_DIN2, exp_fd[2]);
    check("s_vout", S_VOUT, exp_svout);
    check("s_dout", S_DOUT, exp_sdout);
    check("ovf",    OVF,    exp_ovf);
  endtask

  // Called right after a falling edge; ends on the next falling edge.
  task automatic cycle(input logic vin, input logic [NB-1:0] din,
                       input logic fl, input logic fv, input grp_t g);
    logic v;
    grp_t gg;
    if (lb) begin
      v  = d2v;
      gg = d2g;
    end else begin
      v  = fv;
      gg = g;
    end
    d2v = d1v; d2g = d1g;
    d1v = exp_fvin; d1g = exp_fd;
    S_VIN   = vin;
    S_DIN   = din;
    F_VOUT  = v;
    F_DOUT0 = gg[0];
    F_DOUT1 = gg[1];
    F_DOUT2 = gg[2];
`ifdef FIR3_CTRL_FLUSH_EN
    FLUSH = fl;
`endif
    model_step(vin, din, fl, v, gg);
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic drive_zero();
    S_VIN = 1'b0; S_DIN = '0; F_VOUT = 1'b0;
    F_DOUT0 = '0; F_DOUT1 = '0; F_DOUT2 = '0;
`ifdef FIR3_CTRL_FLUSH_EN
    FLUSH = 1'b0;
`endif
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic async_reset();
    #2;
    drive_zero();
    RST = 1'b1;
    #1;
    check("rst_f_vin",  F_VIN,  1'b0);
    check("rst_f_din0", F_DIN0, '0);
    check("rst_f_din1", F_DIN1, '0);
    check("rst_f_din2", F_DIN2, '0);
    check("rst_s_vout", S_VOUT, 1'b0);
    check("rst_s_dout", S_DOUT, '0);
    check("rst_ovf",    OVF,    1'b0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_all();
  endtask

  initial begin
    RST = 1'b1;
    drive_zero();
    model_reset();
    lb = 1'b1;
    @(negedge CLK);
    check_all();
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 1; i <= 6; i++) cycle(1'b1, NB'(i), 1'b0, 1'b0, '0);
    idle(10);

    cycle(1'b1, 13'd7, 1'b0, 1'b0, '0);
    idle(1);
    cycle(1'b1, 13'd8, 1'b0, 1'b0, '0);
    idle(2);
    cycle(1'b1, 13'd9, 1'b0, 1'b0, '0);
    idle(8);

`ifdef FIR3_CTRL_FLUSH_EN
    cycle(1'b1, 13'd10, 1'b0, 1'b0, '0);
    cycle(1'b1, 13'd11, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    idle(2);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    cycle(1'b1, 13'd12, 1'b1, 1'b0, '0);
    idle(8);
`endif

    lb = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b1, mk(13'h0a0, 13'h0a1, 13'h0a2));
    cycle(1'b0, '0, 1'b0, 1'b1, mk(13'h0b0, 13'h0b1, 13'h0b2));
    cycle(1'b0, '0, 1'b0, 1'b1, mk(13'h0c0, 13'h0c1, 13'h0c2));
    check("t5_ovf", OVF, 1'b1);
    idle(8);

    async_reset();
    cycle(1'b0, '0, 1'b0, 1'b1, mk(13'h1a0, 13'h1a1, 13'h1a2));
    cycle(1'b0, '0, 1'b0, 1'b1, mk(13'h1b0, 13'h1b1, 13'h1b2));
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b1, mk(13'h1c0, 13'h1c1, 13'h1c2));
    idle(10);
    check("t6_ovf", OVF, 1'b0);

    lb = 1'b1;
    cycle(1'b1, 13'd21, 1'b0, 1'b0, '0);
    cycle(1'b1, 13'd22, 1'b0, 1'b0, '0);
    async_reset();
    for (int i = 23; i <= 25; i++) cycle(1'b1, NB'(i), 1'b0, 1'b0, '0);
    idle(8);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) async_reset();
      cycle(1'($urandom_range(0, 1)), NB'($urandom),
            ($urandom_range(0, 19) == 0), 1'b0, '0);
    end
    idle(8);

    lb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 900) async_reset();
      cycle(1'($urandom_range(0, 1)), NB'($urandom),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0),
            mk(NB'($urandom), NB'($urandom), NB'($urandom)));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
